// File: rtl/fpu_dp_pkg.sv
// Shared constants for the double-precision FPU command sequencer:
// opcode encodings, controller state encoding and the default datapath width.
package fpu_dp_pkg;

    localparam int DEFAULT_WIDTH = 64;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fpu_dp_sequencer_if.sv
// Bundle of the caller command channel, the result channel and the FPU
// operand/result wires around fpu_dp_sequencer.
// The slave modport is the sequencer's view.
// The master modport is the caller plus FPU side.
interface fpu_dp_sequencer_if #(
    parameter int WIDTH = fpu_dp_pkg::DEFAULT_WIDTH,
    parameter int TAG_W = 4
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic [WIDTH-1:0] fpu_a;
    logic [WIDTH-1:0] fpu_b;
    logic [1:0]       fpu_op;
    logic [WIDTH-1:0] fpu_result;
    logic             fpu_ovf;
    logic             fpu_unf;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_ovf;
    logic             out_unf;
    logic [TAG_W-1:0] out_tag;

    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
               fpu_result, fpu_ovf, fpu_unf,
        input  in_ready, fpu_a, fpu_b, fpu_op, out_valid, out_result,
               out_ovf, out_unf, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
               fpu_result, fpu_ovf, fpu_unf,
        output in_ready, fpu_a, fpu_b, fpu_op, out_valid, out_result,
               out_ovf, out_unf, out_tag, busy
    );

endinterface

// File: rtl/fpu_dp_cmd_fifo.sv
// Strict-order command FIFO holding packed {a, b, op, tag} words.
// A push is ignored when full and a pop is ignored when empty.
// The read side is the head entry, visible combinationally.
module fpu_dp_cmd_fifo #(
    parameter int DATA_W = 134,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_pushData,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_popData,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W:0]    r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_doPush;
    logic              w_doPop;

    assign w_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_doPush  = i_push && !w_full;
    assign w_doPop   = i_pop && !w_empty;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_popData = r_mem[r_rdPtr];

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointers wrap naturally at DEPTH; the count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_dp_sequencer.sv
// Sequences queued FPU commands one at a time.
// For each command it pops the queue and presents registered operands to the
// external FPU. It waits LAT edges, captures the result and flags, and holds
// them on a valid/ready result port.
// Optional feature macro: FPU_DP_SEQ_STICKY_EN adds sticky_clr, sticky_ovf
// and sticky_unf.
module fpu_dp_sequencer
    import fpu_dp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4,
    parameter int LAT   = 2,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef FPU_DP_SEQ_STICKY_EN
    input  logic sticky_clr,
    output logic sticky_ovf,
    output logic sticky_unf,
`endif
    fpu_dp_sequencer_if.slave bus
);

    localparam int DATA_W = 2 * WIDTH + 2 + TAG_W;
    localparam int CNT_W  = $clog2(LAT + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_fpuA;
    logic [WIDTH-1:0]   r_fpuB;
    logic [1:0]         r_fpuOp;
    logic [WIDTH-1:0]   r_outResult;
    logic               r_outOvf;
    logic               r_outUnf;
    logic [TAG_W-1:0]   r_outTag;
    logic               r_outValid;

    logic               w_inReady;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic [DATA_W-1:0]  w_pushData;
    logic [DATA_W-1:0]  w_popData;
    logic [WIDTH-1:0]   w_headA;
    logic [WIDTH-1:0]   w_headB;
    logic [1:0]         w_headOp;
    logic [TAG_W-1:0]   w_headTag;
    logic               w_pop;

    // in_ready is forced low while reset is held so every output reads 0.
    assign w_inReady  = !w_full && !rst;
    assign w_push     = bus.in_valid && w_inReady;
    assign w_pushData = {bus.in_a, bus.in_b, bus.in_op, bus.in_tag};
    assign {w_headA, w_headB, w_headOp, w_headTag} = w_popData;
    assign w_pop      = (r_state == ST_IDLE) && !w_empty;

    fpu_dp_cmd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_cmdFifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pushData (w_pushData),
        .i_pop      (w_pop),
        .o_popData  (w_popData),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Controller: issue the head command, count the FPU latency, then hold
    // the captured result. out_valid rises one edge after DONE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_fpuA      <= '0;
            r_fpuB      <= '0;
            r_fpuOp     <= '0;
            r_outResult <= '0;
            r_outOvf    <= 1'b0;
            r_outUnf    <= 1'b0;
            r_outTag    <= '0;
            r_outValid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_fpuA   <= w_headA;
                        r_fpuB   <= w_headB;
                        r_fpuOp  <= w_headOp;
                        r_outTag <= w_headTag;
                        r_cnt    <= CNT_W'(LAT);
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_outResult <= bus.fpu_result;
                        r_outOvf    <= bus.fpu_ovf;
                        r_outUnf    <= bus.fpu_unf;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!r_outValid) begin
                        r_outValid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_inReady;
    assign bus.fpu_a      = r_fpuA;
    assign bus.fpu_b      = r_fpuB;
    assign bus.fpu_op     = r_fpuOp;
    assign bus.out_valid  = r_outValid;
    assign bus.out_result = r_outResult;
    assign bus.out_ovf    = r_outOvf;
    assign bus.out_unf    = r_outUnf;
    assign bus.out_tag    = r_outTag;
    assign bus.busy       = (r_state != ST_IDLE) || !w_empty;

`ifdef FPU_DP_SEQ_STICKY_EN
    logic r_stickyOvf;
    logic r_stickyUnf;
    logic w_doneHs;

    assign w_doneHs = r_outValid && bus.out_ready;

    // Sticky flags accumulate on delivered results; a set beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stickyOvf <= 1'b0;
            r_stickyUnf <= 1'b0;
        end else begin
            if (w_doneHs && r_outOvf) begin
                r_stickyOvf <= 1'b1;
            end else if (sticky_clr) begin
                r_stickyOvf <= 1'b0;
            end
            if (w_doneHs && r_outUnf) begin
                r_stickyUnf <= 1'b1;
            end else if (sticky_clr) begin
                r_stickyUnf <= 1'b0;
            end
        end
    end

    assign sticky_ovf = r_stickyOvf;
    assign sticky_unf = r_stickyUnf;
`endif

endmodule

// File: tb/tb_fpu_dp_sequencer.sv
// Bench for fpu_dp_sequencer.
// A behavioural FPU with LAT-1 register stages feeds the DUT.
// A transaction scoreboard predicts every delivered result from the commands
// accepted on the input side, using real arithmetic.
module tb_fpu_dp_sequencer;
    import fpu_dp_pkg::*;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [63:0] res;
        logic        ovf;
        logic        unf;
        logic [3:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [65:0] fpuPipe;
    exp_t expQ[$];
    exp_t resQ[$];
    int   hsCycles[$];
    int   cycleNo = 0;
    int   compared = 0;
    int   mismatched = 0;
    bit   randReady = 1'b0;
    bit   prevStall = 1'b0;
    exp_t prevOut;

`ifdef FPU_DP_SEQ_STICKY_EN
    logic stickyClr;
    logic stickyOvf;
    logic stickyUnf;
`endif

    fpu_dp_sequencer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) ifc ();

    fpu_dp_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LAT   (LAT),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef FPU_DP_SEQ_STICKY_EN
        .sticky_clr (stickyClr),
        .sticky_ovf (stickyOvf),
        .sticky_unf (stickyUnf),
`endif
        .bus        (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    function automatic logic [65:0] fpuCalc(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] op);
        real ra, rb, rr;
        logic [63:0] res;
        logic ovf, unf;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        case (op)
            OP_ADD:  rr = ra + rb;
            OP_SUB:  rr = ra - rb;
            OP_MUL:  rr = ra * rb;
            default: rr = ra / rb;
        endcase
        res = $realtobits(rr);
        ovf = (res[62:52] == 11'h7FF) && (a[62:52] != 11'h7FF) && (b[62:52] != 11'h7FF);
        unf = (res[62:52] == 11'h000) && (res[51:0] != 52'h0);
        return {ovf, unf, res};
    endfunction

    // FPU model: result registered LAT-1 times after the operands appear.
    always @(posedge clk) fpuPipe <= fpuCalc(ifc.fpu_a, ifc.fpu_b, ifc.fpu_op);
    assign ifc.fpu_result = fpuPipe[63:0];
    assign ifc.fpu_unf    = fpuPipe[64];
    assign ifc.fpu_ovf    = fpuPipe[65];

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            prevStall = 1'b0;
        end else begin
            if (prevStall && ifc.out_valid) begin
                checkOutput("holdResult", ifc.out_result, prevOut.res);
                checkOutput("holdTag", 64'(ifc.out_tag), 64'(prevOut.tag));
                checkOutput("holdFlags", 64'({ifc.out_ovf, ifc.out_unf}),
                            64'({prevOut.ovf, prevOut.unf}));
            end
            prevStall = ifc.out_valid && !ifc.out_ready;
            prevOut   = '{ifc.out_result, ifc.out_ovf, ifc.out_unf, ifc.out_tag};
            if (ifc.in_valid && ifc.in_ready) begin
                logic [65:0] r;
                r = fpuCalc(ifc.in_a, ifc.in_b, ifc.in_op);
                expQ.push_back('{r[63:0], r[65], r[64], ifc.in_tag});
            end
            if (ifc.out_valid && ifc.out_ready) begin
                exp_t e;
                resQ.push_back('{ifc.out_result, ifc.out_ovf, ifc.out_unf, ifc.out_tag});
                hsCycles.push_back(cycleNo);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedResult", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sbResult", ifc.out_result, e.res);
                    checkOutput("sbTag", 64'(ifc.out_tag), 64'(e.tag));
                    checkOutput("sbOvf", 64'(ifc.out_ovf), 64'(e.ovf));
                    checkOutput("sbUnf", 64'(ifc.out_unf), 64'(e.unf));
                end
            end
        end
    end

    // Random backpressure on out_ready while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) ifc.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] randDouble();
        logic        s;
        logic [10:0] e;
        logic [19:0] mHi;
        logic [31:0] mLo;
        s   = 1'($urandom_range(0, 1));
        e   = 11'h3F0 + 11'($urandom_range(0, 31));
        mHi = 20'($urandom_range(0, 20'hFFFFF));
        mLo = $urandom;
        return {s, e, mHi, mLo};
    endfunction

    // Offer one command; returns after the accepting edge or the cycle bound.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] op, input logic [3:0] tag,
                                 input int maxCycles, output bit accepted);
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_op    = op;
        ifc.in_tag   = tag;
        ifc.in_valid = 1'b1;
        accepted     = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (ifc.in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(posedge clk);
            #1;
            if (!ifc.busy && !ifc.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput("drainTimeout", 64'd0, 64'd1);
        checkOutput("drainQueue", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        bit acc;
        int lat;
        int accCount;
        int validSeen;
        bit seen;

        rst = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_a = '0;
        ifc.in_b = '0;
        ifc.in_op = '0;
        ifc.in_tag = '0;
        ifc.out_ready = 1'b0;
`ifdef FPU_DP_SEQ_STICKY_EN
        stickyClr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetInReady", 64'(ifc.in_ready), 64'd0);
        checkOutput("resetOutValid", 64'(ifc.out_valid), 64'd0);
        checkOutput("resetBusy", 64'(ifc.busy), 64'd0);
        checkOutput("resetFpuA", ifc.fpu_a, 64'd0);
        checkOutput("resetOutResult", ifc.out_result, 64'd0);
        checkOutput("resetOutTag", 64'(ifc.out_tag), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("inReadyAfterReset", 64'(ifc.in_ready), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] directed add with latency check");
        ifc.out_ready = 1'b1;
        applyStimulus(64'h3FF0000000000000, 64'h4000000000000000, OP_ADD, 4'd3, 10, acc);
        checkOutput("acceptAdd", 64'(acc), 64'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (ifc.out_valid) begin
                lat = k;
                break;
            end
        end
        checkOutput("latency", 64'(lat), 64'(LAT + 2));
        checkOutput("addResult", ifc.out_result, 64'h4008000000000000);
        checkOutput("addTag", 64'(ifc.out_tag), 64'd3);
        waitDrain(50);

        $display("[TB] mul then div, order and throughput");
        resQ.delete();
        hsCycles.delete();
        applyStimulus(64'h4000000000000000, 64'h4008000000000000, OP_MUL, 4'd5, 10, acc);
        applyStimulus(64'h4018000000000000, 64'h4000000000000000, OP_DIV, 4'd6, 10, acc);
        waitDrain(60);
        checkOutput("pairCount", 64'(resQ.size()), 64'd2);
        if (resQ.size() == 2) begin
            checkOutput("mulResult", resQ[0].res, 64'h4018000000000000);
            checkOutput("mulTag", 64'(resQ[0].tag), 64'd5);
            checkOutput("divResult", resQ[1].res, 64'h4008000000000000);
            checkOutput("divTag", 64'(resQ[1].tag), 64'd6);
            checkOutput("throughput", 64'(hsCycles[1] - hsCycles[0]), 64'(LAT + 3));
        end

        $display("[TB] backpressure fill and drain");
        ifc.out_ready = 1'b0;
        accCount = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(randDouble(), randDouble(), 2'($urandom_range(0, 3)),
                          4'(i + 1), 8, acc);
            accCount += int'(acc);
        end
        checkOutput("acceptedCount", 64'(accCount), 64'd5);
        checkOutput("inReadyWhenFull", 64'(ifc.in_ready), 64'd0);
        checkOutput("validWhileStalled", 64'(ifc.out_valid), 64'd1);
        resQ.delete();
        ifc.out_ready = 1'b1;
        waitDrain(100);
        checkOutput("drainedCount", 64'(resQ.size()), 64'd5);
        if (resQ.size() == 5) begin
            for (int i = 0; i < 5; i++) checkOutput("drainTagOrder", 64'(resQ[i].tag), 64'(i + 1));
        end

        $display("[TB] overflow flag");
        resQ.delete();
        applyStimulus(64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, OP_MUL, 4'd9, 10, acc);
        waitDrain(50);
        checkOutput("ovfCount", 64'(resQ.size()), 64'd1);
        if (resQ.size() == 1) checkOutput("ovfFlag", 64'(resQ[0].ovf), 64'd1);
`ifdef FPU_DP_SEQ_STICKY_EN
        checkOutput("stickyOvfSet", 64'(stickyOvf), 64'd1);
        checkOutput("stickyUnfQuiet", 64'(stickyUnf), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("stickyOvfHeld", 64'(stickyOvf), 64'd1);
        stickyClr = 1'b1;
        @(posedge clk);
        #1;
        stickyClr = 1'b0;
        checkOutput("stickyOvfCleared", 64'(stickyOvf), 64'd0);
`endif

        $display("[TB] push on the handshake edge with FIFO at DEPTH-1");
        ifc.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(randDouble(), randDouble(), OP_ADD, 4'(i + 10), 8, acc);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ifc.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("edgeValidSeen", 64'(seen), 64'd1);
        ifc.out_ready = 1'b1;
        ifc.in_a = randDouble();
        ifc.in_b = randDouble();
        ifc.in_op = OP_SUB;
        ifc.in_tag = 4'd14;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        checkOutput("pushAtHandshake", 64'(ifc.in_ready), 64'd1);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        checkOutput("fullAfterPush", 64'(ifc.in_ready), 64'd0);
        checkOutput("validClearedAfterHs", 64'(ifc.out_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("readyAfterPop", 64'(ifc.in_ready), 64'd1);
        waitDrain(200);

        $display("[TB] reset during WAIT with two queued");
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(randDouble(), randDouble(), OP_MUL, 4'(i + 1), 10, acc);
        end
        rst = 1'b1;
        #1;
        checkOutput("midRstInReady", 64'(ifc.in_ready), 64'd0);
        checkOutput("midRstOutValid", 64'(ifc.out_valid), 64'd0);
        checkOutput("midRstBusy", 64'(ifc.busy), 64'd0);
        checkOutput("midRstFpuA", ifc.fpu_a, 64'd0);
        checkOutput("midRstFpuOp", 64'(ifc.fpu_op), 64'd0);
        checkOutput("midRstOutResult", ifc.out_result, 64'd0);
        checkOutput("midRstOutTag", 64'(ifc.out_tag), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("postRstInReady", 64'(ifc.in_ready), 64'd1);
        checkOutput("postRstBusy", 64'(ifc.busy), 64'd0);
        validSeen = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifc.out_valid) validSeen++;
        end
        checkOutput("postRstNoValid", 64'(validSeen), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] randomized commands with random backpressure");
        randReady = 1'b1;
        for (int n = 0; n < 40; n++) begin
            applyStimulus(randDouble(), randDouble(), 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)), 60, acc);
            if (!acc) checkOutput("randAccept", 64'd0, 64'd1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        randReady = 1'b0;
        ifc.out_ready = 1'b1;
        waitDrain(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fpu_dp_sequencer.md
FPU_DP_SEQUENCER -- requirements
Module: fpu_dp_sequencer

Interface
REQ-001 Parameter WIDTH, 64, operand/result width in bits.
REQ-002 Parameter DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-003 Parameter LAT, 2, clock edges from fpu_* operands being stable to the FPU result being sampled (>=1).
REQ-004 Parameter TAG_W, 4, width of the caller tag.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  command offered.
REQ-008 in_ready  out  1  command FIFO can accept.
REQ-009 in_a, in_b  in  WIDTH  operands.
REQ-010 in_op  in  2  opcode (0 add, 1 sub, 2 mul, 3 div).
REQ-011 in_tag  in  TAG_W  caller tag, returned with the result.
REQ-012 fpu_a, fpu_b  out  WIDTH  registered operands to the FPU.
REQ-013 fpu_op  out  2  registered opcode to the FPU.
REQ-014 fpu_result  in  WIDTH  FPU result.
REQ-015 fpu_ovf, fpu_unf  in  1  FPU overflow/underflow.
REQ-016 out_valid  out  1  result available.
REQ-017 out_ready  in  1  consumer accepts result.
REQ-018 out_result  out  WIDTH  captured result.
REQ-019 out_ovf, out_unf  out  1  captured flags.
REQ-020 out_tag  out  TAG_W  tag of the result.
REQ-021 busy  out  1  FSM not IDLE or FIFO not empty.

Function
REQ-022 A push occurs on an edge with in_valid && in_ready; in_ready SHALL be !full, so there is no push when full, even if a pop occurs in the same cycle.
REQ-023 FIFO order SHALL be strict; pointers wrap modulo DEPTH; a simultaneous push and pop when not full/empty leaves the count unchanged.
REQ-024 FSM states SHALL be IDLE, WAIT, DONE.
REQ-025 IDLE: if the FIFO is non-empty, pop the head, load fpu_a/fpu_b/fpu_op and the tag, load counter=LAT, go to WAIT; otherwise stay.
REQ-026 WAIT: decrement the counter each edge; on the edge where counter==1, capture fpu_result/fpu_ovf/fpu_unf into out_*, go to DONE.
REQ-027 fpu_a/fpu_b/fpu_op SHALL remain stable from load until leaving WAIT.
REQ-028 DONE: out_valid=1; out_result/out_ovf/out_unf/out_tag SHALL remain stable until out_valid && out_ready; on that edge go to IDLE and clear out_valid.
REQ-029 Latency: with the FIFO empty and FSM in IDLE, out_valid SHALL rise exactly LAT+2 edges after the accepting edge.
REQ-030 Throughput: one operation per LAT+3 cycles when out_ready is held high.
REQ-031 The block SHALL NOT inspect or alter operands; special-value handling belongs to the FPU.

Reset
REQ-032 While rst is high: FIFO empty, FSM IDLE, counter 0, and all outputs 0 (including in_ready, out_valid, fpu_*, out_*, busy).
REQ-033 After rst deasserts, in_ready SHALL be 1 on the first cycle.
REQ-034 Reset mid-operation SHALL discard in-flight and queued commands with no out_valid pulse.

Configuration
REQ-035 With FPU_DP_SEQ_STICKY_EN defined, the block SHALL add input sticky_clr (1) and outputs sticky_ovf and sticky_unf (1 each).
- Each sticky flag is set on any DONE handshake with the corresponding out flag set.
- Each flag is cleared by sticky_clr; set wins over a simultaneous clear.
- Both flags reset to 0.
REQ-036 Without the macro, those ports and registers SHALL be absent.

Structure
REQ-037 Package fpu_dp_pkg SHALL hold the opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV, the FSM state encoding, and the default WIDTH.
REQ-038 The FIFO SHALL be the sub-module fpu_dp_cmd_fifo (data = a, b, op, tag).

Verification
REQ-039 Push add 0x3FF0000000000000 + 0x4000000000000000, tag 3, out_ready=1 -> out_result=0x4008000000000000, out_tag=3, out_valid at accept+LAT+2.
REQ-040 Push mul 0x4000000000000000 * 0x4008000000000000, then div 0x4018000000000000 / 0x4000000000000000 -> results 0x4018000000000000 then 0x4008000000000000, in order, tags preserved.
REQ-041 Hold out_ready=0 and push 6 commands -> after 5 accepted (1 in FSM, 4 queued), in_ready=0; out_* stable; releasing out_ready drains all 5 in order.
REQ-042 Mul 0x7FEFFFFFFFFFFFFF * 0x4000000000000000 -> out_ovf=1; with the macro, sticky_ovf=1 until a sticky_clr pulse.
REQ-043 Assert rst during WAIT with 2 queued -> all outputs 0 immediately; after release, no out_valid, busy=0, in_ready=1.
REQ-044 Push on the same edge as a DONE handshake with the FIFO at DEPTH-1 -> accepted; count=DEPTH; in_ready drops next cycle.
